// File: rtl/mem_l2_responder.sv
// Main-memory responder for L2 block reads and write-backs. It uses an open-row latency model:
// HIT_LAT or MISS_LAT cycles after accept, ready is pulsed for one cycle. Requests are accepted only in IDLE.
module mem_l2_responder #(
  parameter int TNUM     = 18,
  parameter int INUM     = 8,
  parameter int ABITS    = 10,
  parameter int HIT_LAT  = 2,
  parameter int MISS_LAT = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            read_L2_MEM,
  input  logic            write_L2_MEM,
  input  logic [INUM-1:0] index_L2_MEM,
  input  logic [TNUM-1:0] tag_L2_MEM,
  input  logic [INUM-1:0] write_index_L2_MEM,
  input  logic [TNUM-1:0] write_tag_L2_MEM,
  input  logic [511:0]    write_data_L2_MEM,
  output logic            ready_MEM_L2,
  output logic [511:0]    read_data_MEM_L2,
  output logic [15:0]     hit_cnt,
  output logic [15:0]     miss_cnt
);

  localparam int CW    = $clog2(MISS_LAT + 1);
  localparam int DEPTH = 1 << ABITS;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic              op_wr;
  logic [ABITS-1:0]  addr;
  logic [511:0]      wdata;
  logic [TNUM-1:0]   open_tag;
  logic              open_valid;
  logic [DEPTH-1:0]  valid;
  logic [511:0]      mem [DEPTH];
  logic [511:0]      rd_raw;
  logic              rd_hit;

  logic              accept;
  logic [TNUM-1:0]   req_tag;
  logic [INUM-1:0]   req_idx;
  logic [ABITS-1:0]  req_addr;
  logic              row_hit;
  logic              rd_done;

  // Write-back wins over read so a dirty victim lands before its refill.
  assign accept   = (state == IDLE) && (write_L2_MEM || read_L2_MEM);
  assign req_tag  = write_L2_MEM ? write_tag_L2_MEM : tag_L2_MEM;
  assign req_idx  = write_L2_MEM ? write_index_L2_MEM : index_L2_MEM;
  assign req_addr = {req_tag[ABITS-INUM-1:0], req_idx};
  assign row_hit  = open_valid && (req_tag == open_tag);
  assign rd_done  = (state == WAIT) && (cnt == '0) && !op_wr;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: if (accept) begin
        state_n = WAIT;
        cnt_n   = row_hit ? CW'(HIT_LAT - 1) : CW'(MISS_LAT - 1);
      end
      WAIT: if (cnt == '0) state_n = RESP;
            else           cnt_n   = cnt - CW'(1);
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      op_wr      <= 1'b0;
      addr       <= '0;
      wdata      <= '0;
      open_tag   <= '0;
      open_valid <= 1'b0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
      ready_MEM_L2 <= 1'b0;
      rd_hit     <= 1'b0;
      valid      <= '0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      ready_MEM_L2 <= (state_n == RESP);
      if (accept) begin
        op_wr      <= write_L2_MEM;
        addr       <= req_addr;
        wdata      <= write_data_L2_MEM;
        open_tag   <= req_tag;
        open_valid <= 1'b1;
        if (row_hit) begin
          if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
        end else begin
          if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
        end
      end
      if (rd_done) rd_hit <= valid[addr];
      if (state == RESP && op_wr) valid[addr] <= 1'b1;
    end
  end

  // Array storage carries no reset; the valid vector masks stale contents.
  always_ff @(posedge clk) begin
    if (state == RESP && op_wr) mem[addr] <= wdata;
    if (rd_done) rd_raw <= mem[addr];
  end

  assign read_data_MEM_L2 = rd_hit ? rd_raw : '0;

endmodule

// File: tb/tb_mem_l2_responder.sv
// Directed bench for mem_l2_responder: expected latency/data queued at request time, checked on ready.
module tb_mem_l2_responder;

  logic         clk = 1'b0;
  logic         rst;
  logic         read_L2_MEM, write_L2_MEM;
  logic [7:0]   index_L2_MEM, write_index_L2_MEM;
  logic [17:0]  tag_L2_MEM, write_tag_L2_MEM;
  logic [511:0] write_data_L2_MEM;
  logic         ready_MEM_L2;
  logic [511:0] read_data_MEM_L2;
  logic [15:0]  hit_cnt, miss_cnt;

  mem_l2_responder #(.TNUM(18), .INUM(8), .ABITS(10), .HIT_LAT(2), .MISS_LAT(12)) dut (
    .clk(clk), .rst(rst),
    .read_L2_MEM(read_L2_MEM), .write_L2_MEM(write_L2_MEM),
    .index_L2_MEM(index_L2_MEM), .tag_L2_MEM(tag_L2_MEM),
    .write_index_L2_MEM(write_index_L2_MEM), .write_tag_L2_MEM(write_tag_L2_MEM),
    .write_data_L2_MEM(write_data_L2_MEM),
    .ready_MEM_L2(ready_MEM_L2), .read_data_MEM_L2(read_data_MEM_L2),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           lat;
    logic [511:0] data;
    bit           is_rd;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  localparam logic [511:0] D0 = {16{32'hD0D0_0001}};
  localparam logic [511:0] D1 = {16{32'h1111_ABCD}};
  localparam logic [511:0] D2 = {16{32'h2222_5A5A}};

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    read_L2_MEM = 1'b0; write_L2_MEM = 1'b0;
    index_L2_MEM = '0; tag_L2_MEM = '0;
    write_index_L2_MEM = '0; write_tag_L2_MEM = '0; write_data_L2_MEM = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // Counts posedges (sampled at the following negedge) until ready is seen.
  task automatic wait_ready(input int budget, output int n, output bit ok);
    n = 0;
    ok = 1'b0;
    while (n < budget && !ok) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (ready_MEM_L2) ok = 1'b1;
    end
  endtask

  task automatic pop_check(input string tag, input int n, input bit ok);
    exp_t e;
    chk({tag, "_ready_seen"}, 512'(ok), 512'(1));
    if (sb.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 512'(0), 512'(1));
    end else begin
      e = sb.pop_front();
      chk({tag, "_lat"}, 512'(n), 512'(e.lat));
      if (e.is_rd) chk({tag, "_data"}, read_data_MEM_L2, e.data);
    end
  endtask

  // Issues one request at a negedge; accept happens at the next posedge, hence lat+1.
  task automatic do_req(input bit wr, input logic [17:0] tg, input logic [7:0] ix,
                        input logic [511:0] d, input int lat, input logic [511:0] exp_d,
                        input string tag);
    int n;
    bit ok;
    sb.push_back('{lat + 1, exp_d, !wr});
    if (wr) begin
      write_tag_L2_MEM = tg; write_index_L2_MEM = ix; write_data_L2_MEM = d;
      write_L2_MEM = 1'b1;
    end else begin
      tag_L2_MEM = tg; index_L2_MEM = ix;
      read_L2_MEM = 1'b1;
    end
    wait_ready(40, n, ok);
    pop_check(tag, n, ok);
    write_L2_MEM = 1'b0;
    read_L2_MEM  = 1'b0;
    @(negedge clk);
    chk({tag, "_pulse_len"}, 512'(ready_MEM_L2), 512'(0));
  endtask

  initial begin
    int  n;
    bit  ok;
    bit  seen;

    // Reset state and quiet interface.
    apply_reset();
    chk("rst_ready", 512'(ready_MEM_L2), 512'(0));
    chk("rst_rdata", read_data_MEM_L2, '0);
    chk("rst_hit", 512'(hit_cnt), 512'(0));
    chk("rst_miss", 512'(miss_cnt), 512'(0));
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (ready_MEM_L2) seen = 1'b1;
    end
    chk("idle_no_pulse", 512'(seen), 512'(0));

    // Write then read of the same row.
    do_req(1'b1, 18'h00001, 8'd5, D0, 12, '0, "wr_d0");
    chk("wr_d0_miss", 512'(miss_cnt), 512'(1));
    chk("wr_d0_rdata_held", read_data_MEM_L2, '0);
    do_req(1'b0, 18'h00001, 8'd5, '0, 2, D0, "rd_d0");
    chk("rd_d0_hit", 512'(hit_cnt), 512'(1));
    chk("rd_d0_miss", 512'(miss_cnt), 512'(1));

    // Unwritten entry reads as zero.
    apply_reset();
    do_req(1'b0, 18'h00003, 8'd9, '0, 12, '0, "rd_unwr");
    chk("rd_unwr_miss", 512'(miss_cnt), 512'(1));

    // Simultaneous write and read: write served first, read after one idle cycle.
    apply_reset();
    sb.push_back('{13, '0, 1'b0});
    sb.push_back('{14, '0, 1'b1});
    write_tag_L2_MEM = 18'h1; write_index_L2_MEM = 8'd7; write_data_L2_MEM = D1;
    tag_L2_MEM = 18'h2; index_L2_MEM = 8'd7;
    write_L2_MEM = 1'b1; read_L2_MEM = 1'b1;
    wait_ready(40, n, ok);
    pop_check("prio_wr", n, ok);
    write_L2_MEM = 1'b0;
    wait_ready(40, n, ok);
    pop_check("prio_rd", n, ok);
    read_L2_MEM = 1'b0;
    @(negedge clk);
    do_req(1'b0, 18'h00001, 8'd7, '0, 12, D1, "prio_rd_d1");
    chk("prio_miss", 512'(miss_cnt), 512'(3));
    chk("prio_hit", 512'(hit_cnt), 512'(0));

    // Alternating rows never hit.
    apply_reset();
    for (int i = 0; i < 8; i++)
      do_req(1'b0, (i % 2 == 0) ? 18'h10 : 18'h20, 8'd0, '0, 12, '0, "row_sw");
    chk("row_sw_miss", 512'(miss_cnt), 512'(8));
    chk("row_sw_hit", 512'(hit_cnt), 512'(0));

    // Reset during WAIT aborts the write.
    apply_reset();
    write_tag_L2_MEM = 18'h4; write_index_L2_MEM = 8'd1; write_data_L2_MEM = D2;
    write_L2_MEM = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    write_L2_MEM = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (ready_MEM_L2) seen = 1'b1;
    end
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (ready_MEM_L2) seen = 1'b1;
    end
    chk("abort_no_pulse", 512'(seen), 512'(0));
    chk("abort_miss_cleared", 512'(miss_cnt), 512'(0));
    do_req(1'b0, 18'h4, 8'd1, '0, 12, '0, "abort_rd");
    chk("abort_rd_miss", 512'(miss_cnt), 512'(1));

    chk("sb_drained", 512'(sb.size()), 512'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
